// File: rtl/rx_iq_buffer_ctrl_if.sv
// Sample, read-handshake and status bundle between the DDC/bus side and rx_iq_buffer_ctrl.
// slave is the buffer controller's view; master is the driver (DDC plus bus interface) view.
interface rx_iq_buffer_ctrl_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  enable;
  logic signed [15:0]    I;
  logic signed [15:0]    Q;
  logic                  iq_valid;
  logic                  rd_req;
  logic                  clr_flags;
  logic signed [15:0]    I_out;
  logic signed [15:0]    Q_out;
  logic                  rd_ack;
  logic [DEPTH_LOG2:0]   level;
  logic                  streaming;
  logic                  overrun;
  logic                  underrun;
  logic [15:0]           ovr_count;
  logic [15:0]           udr_count;

  modport slave (
    input  enable, I, Q, iq_valid, rd_req, clr_flags,
    output I_out, Q_out, rd_ack, level, streaming, overrun, underrun,
           ovr_count, udr_count
  );

  modport master (
    output enable, I, Q, iq_valid, rd_req, clr_flags,
    input  I_out, Q_out, rd_ack, level, streaming, overrun, underrun,
           ovr_count, udr_count
  );
endinterface

// File: rtl/rx_iq_buffer_ctrl.sv
// RX I/Q sample FIFO between the DDC and the nibble-bus interface, with prime threshold and
// sticky overrun/underrun flags. Define RX_IQ_BUF_STATS_EN to build the 16-bit event counters.
//
// state  | meaning
// FLUSH  | FIFO held empty, writes ignored, reads return 0
// PRIME  | writes accepted, reads return the held sample without popping
// STREAM | writes accepted, each read pops the FIFO head
module rx_iq_buffer_ctrl #(
  parameter int DEPTH_LOG2  = 4,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                 clk_in,
  input  logic                 reset,
  rx_iq_buffer_ctrl_if.slave   bus
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam int                  LW        = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PRIME_LVL = LW'(PRIME_LEVEL);

  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic signed [15:0]      i_out_q, i_out_d;
  logic signed [15:0]      q_out_q, q_out_d;
  logic                    rd_ack_q, rd_ack_d;
  logic                    overrun_q, overrun_d;
  logic                    underrun_q, underrun_d;
  logic [31:0]             mem_q [DEPTH];

  logic push, pop, drop, udr_ev;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    i_out_d    = i_out_q;
    q_out_d    = q_out_q;
    rd_ack_d   = bus.rd_req;
    overrun_d  = overrun_q & ~bus.clr_flags;
    underrun_d = underrun_q & ~bus.clr_flags;
    push       = 1'b0;
    pop        = 1'b0;
    drop       = 1'b0;
    udr_ev     = 1'b0;

    // Dropping enable flushes in the same cycle, whatever state we were in.
    if (!bus.enable || state_q == FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      if (bus.rd_req) begin
        i_out_d = '0;
        q_out_d = '0;
      end
      state_d = bus.enable ? PRIME : FLUSH;
    end else begin
      pop    = bus.rd_req && (state_q == STREAM) && (level_q != '0);
      udr_ev = bus.rd_req && (state_q == STREAM) && (level_q == '0);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
      push   = bus.iq_valid && ((level_q != FULL_LVL) || pop);
      drop   = bus.iq_valid && !push;

      if (pop) begin
        i_out_d  = mem_q[rd_ptr_q][31:16];
        q_out_d  = mem_q[rd_ptr_q][15:0];
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      level_d = level_q + LW'(push) - LW'(pop);

      if (drop)   overrun_d  = 1'b1;
      if (udr_ev) underrun_d = 1'b1;

      unique case (state_q)
        PRIME:   if (level_d >= PRIME_LVL) state_d = STREAM;
        STREAM:  if (udr_ev) state_d = PRIME;
        default: state_d = FLUSH;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= FLUSH;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      i_out_q    <= '0;
      q_out_q    <= '0;
      rd_ack_q   <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      i_out_q    <= i_out_d;
      q_out_q    <= q_out_d;
      rd_ack_q   <= rd_ack_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= {bus.I, bus.Q};
  end

`ifdef RX_IQ_BUF_STATS_EN
  logic [15:0] ovr_cnt_q, ovr_cnt_d;
  logic [15:0] udr_cnt_q, udr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    udr_cnt_d = udr_cnt_q;
    if (bus.clr_flags) begin
      ovr_cnt_d = {15'd0, drop};
      udr_cnt_d = {15'd0, udr_ev};
    end else begin
      if (drop && ovr_cnt_q != 16'hFFFF)   ovr_cnt_d = ovr_cnt_q + 16'd1;
      if (udr_ev && udr_cnt_q != 16'hFFFF) udr_cnt_d = udr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      ovr_cnt_q <= '0;
      udr_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
      udr_cnt_q <= udr_cnt_d;
    end
  end

  assign bus.ovr_count = ovr_cnt_q;
  assign bus.udr_count = udr_cnt_q;
`else
  assign bus.ovr_count = '0;
  assign bus.udr_count = '0;
`endif

  assign bus.I_out     = i_out_q;
  assign bus.Q_out     = q_out_q;
  assign bus.rd_ack    = rd_ack_q;
  assign bus.level     = level_q;
  assign bus.streaming = (state_q == STREAM);
  assign bus.overrun   = overrun_q;
  assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_rx_iq_buffer_ctrl.sv
// Directed bench for rx_iq_buffer_ctrl: priming, read-out order, overrun, underrun,
// simultaneous push/pop on full, flush and mid-stream reset.
module tb_rx_iq_buffer_ctrl;

  logic clk_in = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;
  int   exp_cnt1;

  always #5 clk_in = ~clk_in;

  rx_iq_buffer_ctrl_if #(.DEPTH_LOG2(4)) bus ();

  rx_iq_buffer_ctrl #(.DEPTH_LOG2(4), .PRIME_LEVEL(8)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input int i, input int q);
    bus.I        = 16'(i);
    bus.Q        = 16'(q);
    bus.iq_valid = 1'b1;
    cyc();
    bus.iq_valid = 1'b0;
  endtask

  task automatic rd();
    bus.rd_req = 1'b1;
    cyc();
    bus.rd_req = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"}, bus.level, 0);
    chk({tag, "_strm"},  bus.streaming, 0);
    chk({tag, "_ovr"},   bus.overrun, 0);
    chk({tag, "_udr"},   bus.underrun, 0);
    chk({tag, "_ack"},   bus.rd_ack, 0);
    chk({tag, "_i"},     bus.I_out, 0);
    chk({tag, "_q"},     bus.Q_out, 0);
    chk({tag, "_ocnt"},  bus.ovr_count, 0);
    chk({tag, "_ucnt"},  bus.udr_count, 0);
  endtask

  initial begin
`ifdef RX_IQ_BUF_STATS_EN
    exp_cnt1 = 1;
`else
    exp_cnt1 = 0;
`endif
    reset = 1'b1;
    bus.enable = 1'b0; bus.I = '0; bus.Q = '0;
    bus.iq_valid = 1'b0; bus.rd_req = 1'b0; bus.clr_flags = 1'b0;
    cyc(); cyc();
    chk_reset_state("rst");
    reset = 1'b0;
    cyc();

    // Prime to 8 then stream out in order.
    bus.enable = 1'b1;
    cyc();
    for (int k = 1; k <= 8; k++) begin
      push(k, -k);
      chk("prime_level", bus.level, k);
      if (k == 7) chk("prime_strm7", bus.streaming, 0);
    end
    chk("prime_strm8", bus.streaming, 1);
    for (int k = 1; k <= 8; k++) begin
      rd();
      chk("rd_i", bus.I_out, k);
      chk("rd_q", bus.Q_out, -k);
      chk("rd_ack", bus.rd_ack, 1);
      chk("rd_level", bus.level, 8 - k);
    end
    cyc();
    chk("ack_pulse", bus.rd_ack, 0);

    // Underrun on empty STREAM: hold last sample, back to PRIME.
    rd();
    chk("udr_i", bus.I_out, 8);
    chk("udr_q", bus.Q_out, -8);
    chk("udr_ack", bus.rd_ack, 1);
    chk("udr_flag", bus.underrun, 1);
    chk("udr_strm", bus.streaming, 0);
    chk("udr_cnt", bus.udr_count, exp_cnt1);
    bus.clr_flags = 1'b1; cyc(); bus.clr_flags = 1'b0;
    chk("udr_clr", bus.underrun, 0);

    // Read in PRIME holds and raises no flag.
    rd();
    chk("prm_rd_i", bus.I_out, 8);
    chk("prm_rd_ack", bus.rd_ack, 1);
    chk("prm_rd_udr", bus.underrun, 0);
    chk("prm_rd_lvl", bus.level, 0);

    // Overrun: 17 pushes without reads, last one dropped.
    for (int k = 0; k < 17; k++) begin
      push(100 + k, -(100 + k));
      if (k == 15) chk("full_no_ovr", bus.overrun, 0);
    end
    chk("ovr_level", bus.level, 16);
    chk("ovr_flag", bus.overrun, 1);
    chk("ovr_cnt", bus.ovr_count, exp_cnt1);
    bus.clr_flags = 1'b1; cyc(); bus.clr_flags = 1'b0;
    chk("ovr_clr", bus.overrun, 0);
    chk("ovr_cnt_clr", bus.ovr_count, 0);

    // Full FIFO: push and pop together -> no drop, level unchanged.
    bus.I = 16'(200); bus.Q = 16'(-200);
    bus.iq_valid = 1'b1; bus.rd_req = 1'b1;
    cyc();
    bus.iq_valid = 1'b0; bus.rd_req = 1'b0;
    chk("sim_level", bus.level, 16);
    chk("sim_ovr", bus.overrun, 0);
    chk("sim_i", bus.I_out, 100);
    chk("sim_q", bus.Q_out, -100);

    // Clear together with a new overrun: set wins.
    bus.clr_flags = 1'b1;
    push(201, -201);
    bus.clr_flags = 1'b0;
    chk("clr_set_ovr", bus.overrun, 1);
    chk("clr_set_cnt", bus.ovr_count, exp_cnt1);

    // Drain: 101..115 then 200; dropped 116 and 201 never appear.
    for (int k = 0; k < 16; k++) begin
      rd();
      chk("drain_i", bus.I_out, (k < 15) ? 101 + k : 200);
      chk("drain_q", bus.Q_out, (k < 15) ? -(101 + k) : -200);
    end
    chk("drain_level", bus.level, 0);
    chk("drain_strm", bus.streaming, 1);

    // Flush with level 5.
    for (int k = 1; k <= 5; k++) push(k, k);
    chk("fl_level5", bus.level, 5);
    bus.enable = 1'b0;
    cyc();
    chk("fl_level", bus.level, 0);
    chk("fl_strm", bus.streaming, 0);
    rd();
    chk("fl_rd_i", bus.I_out, 0);
    chk("fl_rd_q", bus.Q_out, 0);
    chk("fl_rd_ack", bus.rd_ack, 1);
    chk("fl_ovr_sticky", bus.overrun, 1);

    // Reset mid-stream.
    bus.enable = 1'b1;
    cyc();
    for (int k = 0; k < 8; k++) push(50 + k, -(50 + k));
    chk("rs_strm", bus.streaming, 1);
    bus.rd_req = 1'b1;
    cyc();
    chk("rs_rd_i", bus.I_out, 50);
    reset = 1'b1;
    cyc();
    bus.rd_req = 1'b0;
    chk_reset_state("midrst");
    reset = 1'b0;
    cyc();
    chk("post_rst_lvl", bus.level, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
